// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA 640x480@60Hz timing constants and frame-buffer geometry
package vga_pkg;

    localparam int H_VIS        = 640;
    localparam int H_FP         = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BP         = 48;
    localparam int H_SYNC_START = H_VIS + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int H_TOTAL      = H_SYNC_END + H_BP;

    localparam int V_VIS        = 480;
    localparam int V_FP         = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BP         = 33;
    localparam int V_SYNC_START = V_VIS + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int V_TOTAL      = V_SYNC_END + V_BP;

    localparam int CLK_DIV   = 4;
    localparam int FB_ADDR_W = 15;
    localparam int CNT_W     = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    // Half-open window test used for both sync pulses.
    function automatic logic in_window(cnt_t v, cnt_t lo, cnt_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/fb_dpram.sv
// rtl/fb_dpram.sv - single-clock 1-bit read-first two-port frame-buffer RAM
module fb_dpram
    import vga_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [FB_ADDR_W-1:0] a_addr,
    input  logic                 a_wdata,
    input  logic                 a_we,
    output logic                 a_rdata,
    input  logic [FB_ADDR_W-1:0] b_addr,
    output logic                 b_rdata
);

    localparam int DEPTH = 1 << FB_ADDR_W;

    logic mem [0:DEPTH-1];
    logic a_rdata_d, a_rdata_q;
    logic b_rdata_d, b_rdata_q;

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
    end

    always_comb begin
        a_rdata_d = mem[a_addr];
        b_rdata_d = mem[b_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata_q <= 1'b0;
            b_rdata_q <= 1'b0;
        end else begin
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/vga_fb_display.sv
// rtl/vga_fb_display.sv - 160x120 1bpp frame buffer scanned out as 640x480 VGA (4x4 blocks)
module vga_fb_display #(
    parameter int H_VIS        = vga_pkg::H_VIS,
    parameter int H_SYNC_START = vga_pkg::H_SYNC_START,
    parameter int H_SYNC_END   = vga_pkg::H_SYNC_END,
    parameter int H_TOTAL      = vga_pkg::H_TOTAL,
    parameter int V_VIS        = vga_pkg::V_VIS,
    parameter int V_SYNC_START = vga_pkg::V_SYNC_START,
    parameter int V_SYNC_END   = vga_pkg::V_SYNC_END,
    parameter int V_TOTAL      = vga_pkg::V_TOTAL
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [vga_pkg::FB_ADDR_W-1:0] A_ADDR,
    input  logic                          A_DATA_IN,
    input  logic                          A_WE,
    output logic                          A_DATA_OUT,
    input  logic [15:0]                   CONFIG_COLOURS,
    output logic                          PIXEL_EN,
    output logic [vga_pkg::FB_ADDR_W-1:0] VGA_ADDR,
    output logic                          VGA_HS,
    output logic                          VGA_VS,
    output logic [7:0]                    VGA_COLOUR
);
    import vga_pkg::*;

    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
    localparam cnt_t H_VIS_C = cnt_t'(H_VIS);
    localparam cnt_t H_SS_C  = cnt_t'(H_SYNC_START);
    localparam cnt_t H_SE_C  = cnt_t'(H_SYNC_END);
    localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_VIS_C = cnt_t'(V_VIS);
    localparam cnt_t V_SS_C  = cnt_t'(V_SYNC_START);
    localparam cnt_t V_SE_C  = cnt_t'(V_SYNC_END);
    localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);

    logic [1:0] div_q, div_d;
    cnt_t       hcnt_q, hcnt_d;
    cnt_t       vcnt_q, vcnt_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic [7:0] colour_q, colour_d;
    logic       pixel_en;
    logic       visible;
    logic       pix_bit;

    fb_dpram u_fb_dpram (
        .clk     (CLK),
        .rst_n   (RESET),
        .a_addr  (A_ADDR),
        .a_wdata (A_DATA_IN),
        .a_we    (A_WE),
        .a_rdata (A_DATA_OUT),
        .b_addr  (VGA_ADDR),
        .b_rdata (pix_bit)
    );

    assign pixel_en = (div_q == DIV_LAST);
    assign visible  = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
    // Each buffer pixel covers a 4x4 screen block, so drop the two LSBs of each counter.
    assign VGA_ADDR = {vcnt_q[8:2], hcnt_q[9:2]};

    // Counters hold for a full tick, so pix_bit already matches them when outputs latch.
    always_comb begin
        div_d    = div_q + 2'd1;
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        colour_d = colour_q;
        if (pixel_en) begin
            hs_d     = !in_window(hcnt_q, H_SS_C, H_SE_C);
            vs_d     = !in_window(vcnt_q, V_SS_C, V_SE_C);
            colour_d = !visible ? 8'h00 :
                       (pix_bit ? CONFIG_COLOURS[7:0] : CONFIG_COLOURS[15:8]);
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + cnt_t'(1);
            end else begin
                hcnt_d = hcnt_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            div_q    <= 2'd0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            colour_q <= 8'h00;
        end else begin
            div_q    <= div_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            colour_q <= colour_d;
        end
    end

    assign PIXEL_EN   = pixel_en;
    assign VGA_HS     = hs_q;
    assign VGA_VS     = vs_q;
    assign VGA_COLOUR = colour_q;

endmodule

// File: tb/tb_vga_fb_display.sv
// tb/tb_vga_fb_display.sv - directed bench for vga_fb_display (short vertical frame)
module tb_vga_fb_display;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] a_addr;
    logic        a_data_in;
    logic        a_we;
    logic        a_data_out;
    logic [15:0] config_colours;
    logic        pixel_en;
    logic [14:0] vga_addr;
    logic        vga_hs;
    logic        vga_vs;
    logic [7:0]  vga_colour;

    int vecs  = 0;
    int fails = 0;
    int ec;

    typedef enum int {SIG_PEN, SIG_HS, SIG_VS, SIG_COL, SIG_ADDR, SET_CFG} sig_e;
    typedef struct {
        int   ec;
        sig_e sig;
        int   val;
    } tv_t;
    typedef struct {
        logic [14:0] addr;
        logic        din;
        logic        we;
        logic        exp;
    } pa_t;

    tv_t frame_tv[$];
    tv_t post_tv[$];
    pa_t pa_tv[$];

    // Seven-line frame: visible 0..3, VS low on line 5.
    vga_fb_display #(
        .V_VIS        (4),
        .V_SYNC_START (5),
        .V_SYNC_END   (6),
        .V_TOTAL      (7)
    ) dut (
        .CLK            (clk),
        .RESET          (reset_n),
        .A_ADDR         (a_addr),
        .A_DATA_IN      (a_data_in),
        .A_WE           (a_we),
        .A_DATA_OUT     (a_data_out),
        .CONFIG_COLOURS (config_colours),
        .PIXEL_EN       (pixel_en),
        .VGA_ADDR       (vga_addr),
        .VGA_HS         (vga_hs),
        .VGA_VS         (vga_vs),
        .VGA_COLOUR     (vga_colour)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ec <= 0;
        else          ec <= ec + 1;
    end

    function automatic tv_t tv(int e, sig_e s, int v);
        tv_t t;
        t.ec  = e;
        t.sig = s;
        t.val = v;
        return t;
    endfunction

    function automatic pa_t pa(logic [14:0] addr, logic din, logic we, logic exp);
        pa_t p;
        p.addr = addr;
        p.din  = din;
        p.we   = we;
        p.exp  = exp;
        return p;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_tv(input tv_t t);
        int guard;
        int act;
        guard = 0;
        while (ec < t.ec && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (ec != t.ec) begin
            check("schedule", ec, t.ec);
            return;
        end
        if (t.sig == SET_CFG) begin
            config_colours = 16'(t.val);
            return;
        end
        case (t.sig)
            SIG_PEN:  act = int'(pixel_en);
            SIG_HS:   act = int'(vga_hs);
            SIG_VS:   act = int'(vga_vs);
            SIG_COL:  act = int'(vga_colour);
            SIG_ADDR: act = int'(vga_addr);
            default:  act = -1;
        endcase
        check($sformatf("%s@clk%0d", t.sig.name(), t.ec), act, t.val);
    endtask

    task automatic pa_write(input logic [14:0] addr, input logic din);
        a_addr    = addr;
        a_data_in = din;
        a_we      = 1'b1;
        @(negedge clk);
        a_we      = 1'b0;
    endtask

    initial begin
        frame_tv = '{};
        frame_tv.push_back(tv(1,     SIG_PEN,  0));
        frame_tv.push_back(tv(2,     SIG_PEN,  0));
        frame_tv.push_back(tv(3,     SIG_PEN,  1));
        frame_tv.push_back(tv(4,     SIG_PEN,  0));
        frame_tv.push_back(tv(4,     SIG_COL,  'h33));
        frame_tv.push_back(tv(5,     SIG_PEN,  0));
        frame_tv.push_back(tv(6,     SIG_PEN,  0));
        frame_tv.push_back(tv(7,     SIG_PEN,  1));
        frame_tv.push_back(tv(8,     SIG_PEN,  0));
        frame_tv.push_back(tv(8,     SIG_COL,  'h33));
        frame_tv.push_back(tv(12,    SIG_COL,  'h33));
        frame_tv.push_back(tv(16,    SIG_COL,  'h33));
        frame_tv.push_back(tv(19,    SIG_COL,  'h33));
        frame_tv.push_back(tv(20,    SIG_COL,  'hCC));
        frame_tv.push_back(tv(20,    SIG_ADDR, 'h0001));
        frame_tv.push_back(tv(2560,  SIG_COL,  'hCC));
        frame_tv.push_back(tv(2564,  SIG_COL,  'h00));
        frame_tv.push_back(tv(2627,  SIG_HS,   1));
        frame_tv.push_back(tv(2628,  SIG_HS,   0));
        frame_tv.push_back(tv(3011,  SIG_HS,   0));
        frame_tv.push_back(tv(3012,  SIG_HS,   1));
        frame_tv.push_back(tv(3204,  SIG_COL,  'h33));
        frame_tv.push_back(tv(3602,  SET_CFG,  'hFF00));
        frame_tv.push_back(tv(3603,  SIG_COL,  'hCC));
        frame_tv.push_back(tv(3604,  SIG_COL,  'hFF));
        frame_tv.push_back(tv(5827,  SIG_HS,   1));
        frame_tv.push_back(tv(5828,  SIG_HS,   0));
        frame_tv.push_back(tv(6420,  SIG_COL,  'hFF));
        frame_tv.push_back(tv(12804, SIG_COL,  'h00));
        frame_tv.push_back(tv(12881, SIG_ADDR, 'h0105));
        frame_tv.push_back(tv(16003, SIG_VS,   1));
        frame_tv.push_back(tv(16004, SIG_VS,   0));
        frame_tv.push_back(tv(19203, SIG_VS,   0));
        frame_tv.push_back(tv(19204, SIG_VS,   1));
        frame_tv.push_back(tv(38403, SIG_VS,   1));
        frame_tv.push_back(tv(38404, SIG_VS,   0));
        frame_tv.push_back(tv(41100, SIG_HS,   0));
        frame_tv.push_back(tv(41100, SIG_VS,   0));

        post_tv = '{};
        post_tv.push_back(tv(4,    SIG_COL, 'h33));
        post_tv.push_back(tv(20,   SIG_COL, 'hCC));
        post_tv.push_back(tv(2627, SIG_HS,  1));
        post_tv.push_back(tv(2628, SIG_HS,  0));

        pa_tv = '{};
        pa_tv.push_back(pa(15'h0105, 1'b1, 1'b1, 1'b0));
        pa_tv.push_back(pa(15'h0105, 1'b0, 1'b0, 1'b1));
        pa_tv.push_back(pa(15'h0105, 1'b0, 1'b1, 1'b1));
        pa_tv.push_back(pa(15'h0105, 1'b0, 1'b0, 1'b0));
        pa_tv.push_back(pa(15'h7FFF, 1'b1, 1'b1, 1'b0));
        pa_tv.push_back(pa(15'h7FFF, 1'b0, 1'b0, 1'b1));
        pa_tv.push_back(pa(15'h0000, 1'b0, 1'b0, 1'b1));
        pa_tv.push_back(pa(15'h0001, 1'b0, 1'b0, 1'b0));
        pa_tv.push_back(pa(15'h4A9F, 1'b1, 1'b1, 1'b0));
        pa_tv.push_back(pa(15'h4A9F, 1'b0, 1'b0, 1'b1));
        pa_tv.push_back(pa(15'h7FFF, 1'b0, 1'b1, 1'b1));
        pa_tv.push_back(pa(15'h7FFF, 1'b0, 1'b0, 1'b0));

        reset_n        = 1'b1;
        config_colours = 16'hCC33;
        a_addr         = '0;
        a_data_in      = 1'b0;
        a_we           = 1'b0;
        #2 reset_n = 1'b0;
        @(negedge clk);

        for (int x = 0; x < 160; x++) pa_write(15'(x), 1'b0);
        pa_write(15'h0000, 1'b1);
        pa_write(15'h0105, 1'b0);
        pa_write(15'h7FFF, 1'b0);
        pa_write(15'h4A9F, 1'b0);
        repeat (10) @(negedge clk);

        check("reset_hs",       int'(vga_hs),     1);
        check("reset_vs",       int'(vga_vs),     1);
        check("reset_colour",   int'(vga_colour), 0);
        check("reset_a_dout",   int'(a_data_out), 0);
        check("reset_pixel_en", int'(pixel_en),   0);
        check("reset_vga_addr", int'(vga_addr),   0);

        a_addr  = 15'h0000;
        reset_n = 1'b1;
        foreach (frame_tv[i]) run_tv(frame_tv[i]);

        check("pre_reset_a_dout", int'(a_data_out), 1);
        reset_n = 1'b0;
        #1;
        check("midreset_hs",       int'(vga_hs),     1);
        check("midreset_vs",       int'(vga_vs),     1);
        check("midreset_colour",   int'(vga_colour), 0);
        check("midreset_pixel_en", int'(pixel_en),   0);
        check("midreset_a_dout",   int'(a_data_out), 0);
        config_colours = 16'hCC33;
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
        foreach (post_tv[i]) run_tv(post_tv[i]);

        foreach (pa_tv[i]) begin
            a_addr    = pa_tv[i].addr;
            a_data_in = pa_tv[i].din;
            a_we      = pa_tv[i].we;
            @(negedge clk);
            check($sformatf("porta_vec%0d", i), int'(a_data_out), int'(pa_tv[i].exp));
        end
        a_we = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
